// File: rtl/sdram_sched_pkg.sv
// Shared constants and types for the SDRAM packet scheduler.
package sdram_sched_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // Queue entries carry a channel id 0..num_ch-1, or num_ch for a read.
  function automatic int op_width(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/sched_req_fifo.sv
// Arrival-order request queue. Several entries may be written in one cycle
// (lanes 0..wr_cnt-1, lane 0 oldest); the writer never exceeds free space.
module sched_req_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int LANES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(LANES+1)-1:0] wr_cnt,
  input  logic [LANES*W-1:0]         wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer/count update with multi-lane write and single-entry read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(wr_cnt)) mem[wr_ptr + PW'(i)] <= wr_data[i*W +: W];
      end
      wr_ptr <= wr_ptr + PW'(wr_cnt);
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_cnt) - CW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/sdram_packet_scheduler.sv
// Queues whole-packet writes from sensor channels and downlink read requests
// in arrival order, then serialises them into SDRAM commands one word at a time.
// Handshake: a channel packet transfers on a cycle where PKT_VALID[c] and
// PKT_READY[c] are both 1; PKT_READY[c] stays low until that packet's last
// word completes (or until it is dropped on a full queue, when it stays high).
module sdram_packet_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int MAX_WORDS   = 5,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          CLK_48MHZ,
  input  logic                          RESET_N,
  input  logic [NUM_CH-1:0]             PKT_VALID,
  output logic [NUM_CH-1:0]             PKT_READY,
  input  logic [NUM_CH*MAX_WORDS*16-1:0] PKT_DATA,
  input  logic [NUM_CH*4-1:0]           PKT_LEN,
  input  logic                          READ_CMD,
  input  logic                          SDRAM_STATUS,
  input  logic [1:0]                    BA_WRITE,
  input  logic [12:0]                   ROW_WRITE,
  input  logic [8:0]                    COL_WRITE,
  input  logic [1:0]                    BA_READ,
  input  logic [12:0]                   ROW_READ,
  input  logic [8:0]                    COL_READ,
  output logic [1:0]                    CMD_OUT,
  output logic [1:0]                    BA_OUT,
  output logic [12:0]                   ROW_OUT,
  output logic [8:0]                    COL_OUT,
  output logic [15:0]                   DATA_OUT,
  output logic                          NEXT_WRITE,
  output logic                          NEXT_READ,
  output logic                          OVERFLOW,
  output sched_state_t                  DBG_STATE
);

  localparam int             OPW     = op_width(NUM_CH);
  localparam logic [OPW-1:0] OP_READ = OPW'(NUM_CH);
  localparam int             PKTW    = MAX_WORDS * 16;
  localparam int             LANES   = NUM_CH + 1;
  localparam int             NW      = $clog2(LANES + 1);
  localparam int             CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [3:0]     MAXW4   = 4'(MAX_WORDS);

  sched_state_t state_q, state_d;

  logic [PKTW-1:0]    buf_q [NUM_CH];
  logic [3:0]         len_q [NUM_CH];
  logic [NUM_CH-1:0]  pkt_ready_q;
  logic               overflow_q;
  logic               read_hist_q;
  logic [OPW-1:0]     cur_op_q;
  logic [3:0]         word_idx_q;
  logic               issue_first_q;
  logic [23:0]        held_addr_q;

  logic               read_rise;
  logic [NUM_CH-1:0]  accept;
  logic               drop;
  logic [NW-1:0]      wr_cnt;
  logic [LANES*OPW-1:0] wr_data;
  logic               pop;
  logic [OPW-1:0]     fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               is_write;
  logic               last_word;
  logic               release_pkt;
  logic [15:0]        cur_word;
  logic [3:0]         cur_len;
  logic [23:0]        live_addr;
  logic [23:0]        addr_sel;

  assign read_rise = READ_CMD & ~read_hist_q;
  assign is_write  = (cur_op_q != OP_READ);

  sched_req_fifo #(
    .W     (OPW),
    .DEPTH (QUEUE_DEPTH),
    .LANES (LANES)
  ) u_fifo (
    .clk     (CLK_48MHZ),
    .rst_n   (RESET_N),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pack this cycle's requests (channels ascending, then read) into free slots.
  always_comb begin
    int n;
    int space;
    n       = 0;
    space   = (fifo_full && !pop) ? 0 : QUEUE_DEPTH - int'(fifo_count) + (pop ? 1 : 0);
    wr_data = '0;
    accept  = '0;
    drop    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (PKT_VALID[c] && pkt_ready_q[c]) begin
        if (n < space) begin
          wr_data[n*OPW +: OPW] = OPW'(c);
          accept[c] = 1'b1;
          n++;
        end else begin
          drop = 1'b1;
        end
      end
    end
    if (read_rise) begin
      if (n < space) begin
        wr_data[n*OPW +: OPW] = OP_READ;
        n++;
      end else begin
        drop = 1'b1;
      end
    end
    wr_cnt = NW'(n);
  end

  // Select the current packet's word and length from its channel buffer.
  always_comb begin
    cur_word = '0;
    cur_len  = 4'd1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_op_q == OPW'(c)) begin
        cur_word = buf_q[c][int'(word_idx_q)*16 +: 16];
        cur_len  = len_q[c];
      end
    end
  end

  assign last_word   = ({1'b0, word_idx_q} + 5'd1) >= {1'b0, cur_len};
  assign release_pkt = (state_q == ST_DONE) && is_write && last_word;

  // Next-state and command strobes.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    CMD_OUT    = CMD_NOP;
    NEXT_WRITE = 1'b0;
    NEXT_READ  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        CMD_OUT = is_write ? CMD_WRITE : CMD_READ;
        if (SDRAM_STATUS) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (!SDRAM_STATUS) state_d = ST_DONE;
      end
      ST_DONE: begin
        NEXT_WRITE = is_write;
        NEXT_READ  = !is_write;
        state_d    = (is_write && !last_word) ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first ISSUE cycle passes the live address through so a counter that
  // advanced on the preceding NEXT_WRITE is seen; it is then held.
  always_comb begin
    live_addr = is_write ? {BA_WRITE, ROW_WRITE, COL_WRITE} : {BA_READ, ROW_READ, COL_READ};
    addr_sel  = issue_first_q ? live_addr : held_addr_q;
    {BA_OUT, ROW_OUT, COL_OUT} = '0;
    DATA_OUT  = '0;
    if (state_q == ST_ISSUE) begin
      {BA_OUT, ROW_OUT, COL_OUT} = addr_sel;
      if (is_write) DATA_OUT = cur_word;
    end
  end

  // Control state: FSM, current op, word index, handshake and sticky overflow.
  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      cur_op_q      <= '0;
      word_idx_q    <= '0;
      issue_first_q <= 1'b0;
      held_addr_q   <= '0;
      read_hist_q   <= 1'b0;
      pkt_ready_q   <= '1;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_hist_q   <= READ_CMD;
      issue_first_q <= (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
      if (pop) begin
        cur_op_q   <= fifo_head;
        word_idx_q <= '0;
      end else if (state_q == ST_DONE && state_d == ST_ISSUE) begin
        word_idx_q <= word_idx_q + 4'd1;
      end
      if (state_q == ST_ISSUE && issue_first_q) held_addr_q <= live_addr;
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) pkt_ready_q[c] <= 1'b0;
        else if (release_pkt && cur_op_q == OPW'(c)) pkt_ready_q[c] <= 1'b1;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Packet buffers capture on acceptance; out-of-range lengths become MAX_WORDS.
  always_ff @(posedge CLK_48MHZ) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) begin
        buf_q[c] <= PKT_DATA[c*PKTW +: PKTW];
        len_q[c] <= (PKT_LEN[c*4 +: 4] == 4'd0 || PKT_LEN[c*4 +: 4] > MAXW4) ?
                    MAXW4 : PKT_LEN[c*4 +: 4];
      end
    end
  end

  assign PKT_READY = pkt_ready_q;
  assign OVERFLOW  = overflow_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sdram_packet_scheduler.sv
// Directed bench for sdram_packet_scheduler with an SDRAM responder model,
// address counters and a command scoreboard.
module tb_sdram_packet_scheduler;
  import sdram_sched_pkg::*;

  localparam int NUM_CH      = 2;
  localparam int MAX_WORDS   = 5;
  localparam int QUEUE_DEPTH = 4;
  localparam int PKTW        = MAX_WORDS * 16;
  localparam int EW          = 42;
  localparam logic [1:0]  BA_W  = 2'b01;
  localparam logic [12:0] ROW_W = 13'h0123;
  localparam logic [1:0]  BA_R  = 2'b10;
  localparam logic [12:0] ROW_R = 13'h0456;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [NUM_CH-1:0]        pkt_valid = '0;
  logic [NUM_CH-1:0]        pkt_ready;
  logic [NUM_CH*PKTW-1:0]   pkt_data = '0;
  logic [NUM_CH*4-1:0]      pkt_len = '0;
  logic                     read_cmd = 1'b0;
  logic                     sdram_status = 1'b0;
  logic [1:0]               ba_write = BA_W;
  logic [12:0]              row_write = ROW_W;
  logic [8:0]               col_write = 9'h010;
  logic [1:0]               ba_read = BA_R;
  logic [12:0]              row_read = ROW_R;
  logic [8:0]               col_read = 9'h100;
  logic [1:0]               cmd_out;
  logic [1:0]               ba_out;
  logic [12:0]              row_out;
  logic [8:0]               col_out;
  logic [15:0]              data_out;
  logic                     next_write;
  logic                     next_read;
  logic                     overflow;
  sched_state_t             dbg_state;

  sdram_packet_scheduler #(
    .NUM_CH      (NUM_CH),
    .MAX_WORDS   (MAX_WORDS),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .CLK_48MHZ    (clk),
    .RESET_N      (rst_n),
    .PKT_VALID    (pkt_valid),
    .PKT_READY    (pkt_ready),
    .PKT_DATA     (pkt_data),
    .PKT_LEN      (pkt_len),
    .READ_CMD     (read_cmd),
    .SDRAM_STATUS (sdram_status),
    .BA_WRITE     (ba_write),
    .ROW_WRITE    (row_write),
    .COL_WRITE    (col_write),
    .BA_READ      (ba_read),
    .ROW_READ     (row_read),
    .COL_READ     (col_read),
    .CMD_OUT      (cmd_out),
    .BA_OUT       (ba_out),
    .ROW_OUT      (row_out),
    .COL_OUT      (col_out),
    .DATA_OUT     (data_out),
    .NEXT_WRITE   (next_write),
    .NEXT_READ    (next_read),
    .OVERFLOW     (overflow),
    .DBG_STATE    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int nw_cnt = 0;
  int nr_cnt = 0;
  int resp_cnt = 0;
  int busy_len = 2;
  bit force_busy = 1'b0;
  logic [1:0] prev_cmd = CMD_NOP;
  logic [8:0] exp_wcol = 9'h010;
  logic [8:0] exp_rcol = 9'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_write(input logic [15:0] data);
    exp_q.push_back({CMD_WRITE, BA_W, ROW_W, exp_wcol, data});
    exp_wcol = exp_wcol + 9'd1;
  endtask

  task automatic push_read();
    exp_q.push_back({CMD_READ, BA_R, ROW_R, exp_rcol, 16'h0000});
    exp_rcol = exp_rcol + 9'd1;
  endtask

  task automatic load_pkt(input int c, input logic [3:0] len, input logic [PKTW-1:0] words,
                          input int n_exp);
    pkt_valid[c] = 1'b1;
    pkt_data[c*PKTW +: PKTW] = words;
    pkt_len[c*4 +: 4] = len;
    for (int i = 0; i < n_exp; i++) push_write(words[i*16 +: 16]);
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == ST_IDLE && resp_cnt == 0 &&
          !sdram_status && pkt_ready == '1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_state(input string tag, input sched_state_t st);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (dbg_state == st) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // SDRAM model: goes busy when a command appears and stays busy busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (force_busy) begin
        sdram_status = 1'b1;
        resp_cnt = 1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) sdram_status = 1'b0;
      end else if (cmd_out != CMD_NOP) begin
        sdram_status = 1'b1;
        resp_cnt = busy_len;
      end
    end
  end

  // Address counters advance on each completion pulse.
  initial begin
    logic nw_s, nr_s;
    forever begin
      @(negedge clk);
      nw_s = next_write;
      nr_s = next_read;
      @(posedge clk);
      #1;
      if (nw_s) col_write = col_write + 9'd1;
      if (nr_s) col_read = col_read + 9'd1;
    end
  end

  // Monitor: compare each new command against the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (cmd_out != CMD_NOP && prev_cmd == CMD_NOP) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", 64'(cmd_out), 64'(CMD_NOP));
      end else begin
        e = exp_q.pop_front();
        got = {cmd_out, ba_out, row_out, col_out, data_out};
        if (e[41:40] == CMD_READ) begin
          got[15:0] = 16'h0000;
          e[15:0] = 16'h0000;
        end
        check("cmd", 64'(got), 64'(e));
      end
    end
    prev_cmd = cmd_out;
    if (next_write) nw_cnt++;
    if (next_read) nr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base_w, base_r, k;
    bit ok;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", 64'(cmd_out), 64'(CMD_NOP));
    check("rst_ready", 64'(pkt_ready), 64'h3);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_next_write", 64'(next_write), 64'd0);
    check("rst_next_read", 64'(next_read), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: ch0 three-word packet, latency and ready release
    @(posedge clk); #1;
    base_w = nw_cnt;
    load_pkt(0, 4'd3, {16'h0, 16'h0, 16'h3333, 16'h2222, 16'h1111}, 3);
    @(posedge clk); #1;
    pkt_valid = '0;
    @(negedge clk);
    check("t1_ready_drop", 64'(pkt_ready[0]), 64'd0);
    check("t1_cmd_lat0", 64'(cmd_out), 64'(CMD_NOP));
    @(negedge clk);
    check("t1_cmd_lat1", 64'(cmd_out), 64'(CMD_WRITE));
    k = 0;
    for (int t = 0; t < 100 && k < 3; t++) begin
      @(negedge clk);
      if (next_write) k++;
    end
    check("t1_pulses", 64'(k), 64'd3);
    check("t1_ready_at_last", 64'(pkt_ready[0]), 64'd0);
    @(negedge clk);
    check("t1_ready_back", 64'(pkt_ready[0]), 64'd1);
    wait_drain("t1_drain");
    check("t1_nw_total", 64'(nw_cnt - base_w), 64'd3);

    // Test 2: ch0 + ch1 + read edge in one cycle
    @(posedge clk); #1;
    base_w = nw_cnt;
    base_r = nr_cnt;
    load_pkt(0, 4'd2, {16'h0, 16'h0, 16'h0, 16'hA002, 16'hA001}, 2);
    load_pkt(1, 4'd2, {16'h0, 16'h0, 16'h0, 16'hB002, 16'hB001}, 2);
    read_cmd = 1'b1;
    push_read();
    @(posedge clk); #1;
    pkt_valid = '0;
    read_cmd = 1'b0;
    @(negedge clk);
    check("t2_ready_both_low", 64'(pkt_ready), 64'h0);
    wait_drain("t2_drain");
    check("t2_nr", 64'(nr_cnt - base_r), 64'd1);
    check("t2_nw", 64'(nw_cnt - base_w), 64'd4);

    // Test 3: five read edges while the FSM is stalled
    @(posedge clk); #1;
    base_w = nw_cnt;
    base_r = nr_cnt;
    load_pkt(0, 4'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'hAAAA}, 1);
    @(posedge clk); #1;
    pkt_valid = '0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_out == CMD_WRITE) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_write_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      read_cmd = 1'b1;
      if (i < QUEUE_DEPTH) push_read();
      @(posedge clk); #1;
      read_cmd = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_stalled", 64'(dbg_state), 64'(ST_BUSY));
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_drain("t3_drain");
    check("t3_nr", 64'(nr_cnt - base_r), 64'd4);
    check("t3_nw", 64'(nw_cnt - base_w), 64'd1);
    check("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Test 4: reset during BUSY of the second word
    @(posedge clk); #1;
    load_pkt(1, 4'd3, {16'h0, 16'h0, 16'hC003, 16'hC002, 16'hC001}, 3);
    @(posedge clk); #1;
    pkt_valid = '0;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (next_write) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_first_word_done", 64'(ok), 64'd1);
    wait_state("t4_word2_busy", ST_BUSY);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_cnt = 0;
    sdram_status = 1'b0;
    exp_q.delete();
    base_w = nw_cnt;
    @(negedge clk);
    check("t4_cmd", 64'(cmd_out), 64'(CMD_NOP));
    check("t4_ready", 64'(pkt_ready), 64'h3);
    check("t4_next_write", 64'(next_write), 64'd0);
    check("t4_overflow_cleared", 64'(overflow), 64'd0);
    check("t4_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (4) @(negedge clk);
    check("t4_no_pulse", 64'(nw_cnt - base_w), 64'd0);
    exp_wcol = col_write;
    exp_rcol = col_read;
    @(posedge clk); #1;
    load_pkt(1, 4'd2, {16'h0, 16'h0, 16'h0, 16'h5A02, 16'h5A01}, 2);
    @(posedge clk); #1;
    pkt_valid = '0;
    wait_drain("t4_drain");

    // Test 5: PKT_LEN 0 and PKT_LEN above MAX_WORDS both clamp to five words
    @(posedge clk); #1;
    base_w = nw_cnt;
    load_pkt(0, 4'd0, {16'hD005, 16'hD004, 16'hD003, 16'hD002, 16'hD001}, 5);
    @(posedge clk); #1;
    pkt_valid = '0;
    wait_drain("t5_len0_drain");
    check("t5_len0_nw", 64'(nw_cnt - base_w), 64'd5);
    @(posedge clk); #1;
    base_w = nw_cnt;
    load_pkt(1, 4'd7, {16'hE005, 16'hE004, 16'hE003, 16'hE002, 16'hE001}, 5);
    @(posedge clk); #1;
    pkt_valid = '0;
    wait_drain("t5_len7_drain");
    check("t5_len7_nw", 64'(nw_cnt - base_w), 64'd5);

    // Test 6: READ_CMD held high for ten cycles
    @(posedge clk); #1;
    base_r = nr_cnt;
    read_cmd = 1'b1;
    push_read();
    repeat (10) @(posedge clk);
    #1;
    read_cmd = 1'b0;
    wait_drain("t6_drain");
    check("t6_nr", 64'(nr_cnt - base_r), 64'd1);
    check("t6_overflow", 64'(overflow), 64'd0);

    // Final report
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
